enc8_3_seq: RTL and testbench
=============================

ENC8_3_SEQ -- requirements
Module: enc8_3_seq

Interface
REQ-001 Parameter: PRIO_HIGH, default 1, priority order (1: bit 7 highest; 0: bit 0 highest).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 load  input  1  capture strobe for A, sampled on rising clk.
REQ-005 A  input  8  event word; any number of bits may be set.
REQ-006 ready  input  1  consumer accepts Y when high.
REQ-007 Y  output  3  encoded index of the offered event bit (registered).
REQ-008 valid  output  1  Y holds an offered code (registered).
REQ-009 pend_cnt  output  4  number of pending bits, including the offered one (registered, 0..8).
REQ-010 dup  output  1  one-cycle pulse: a loaded bit was already pending (registered).

Function
REQ-011 The block SHALL hold an 8-bit pending register; it is the 8-to-3 encoding counterpart of the team's 3-to-8 decoder, servicing each set bit as one code.
REQ-012 FSM states SHALL be IDLE (valid=0) and OFFER (valid=1).
REQ-013 Transfer SHALL occur on a rising edge with valid=1 and ready=1; the bit indexed by Y is then cleared from pending.
REQ-014 pending_next SHALL equal (pending with transferred bit cleared) OR (A if load=1, else 0).
REQ-015 load with A=8'h00 SHALL have no effect on any state or output.
REQ-016 IDLE -> OFFER when pending_next != 0; Y SHALL be the priority-selected index of pending_next (latency: valid high on the cycle after the load edge).
REQ-017 OFFER with no transfer SHALL hold Y and valid stable, even if load adds a higher-priority bit.
REQ-018 OFFER with transfer: if pending_next != 0, stay in OFFER with Y = priority index of pending_next on the next cycle (back-to-back, no bubble); else go to IDLE with valid=0 and Y retaining its value.
REQ-019 pend_cnt SHALL equal popcount(pending) at every cycle.
REQ-020 dup SHALL pulse high for exactly one cycle after an edge where load=1 and (A AND pending AND NOT transferred-bit) != 0; otherwise 0.
REQ-021 A bit transferred and re-loaded on the same edge SHALL be set pending again without asserting dup.
REQ-022 No combinational path SHALL exist from any input to any output.

Reset
REQ-023 rst_n low SHALL immediately clear pending=0, Y=3'b000, valid=0, pend_cnt=0, dup=0, state IDLE, including mid-OFFER.
REQ-024 After rst_n deasserts, the first load SHALL be honoured on the next rising edge.

Verification
REQ-025 Load A=8'b0000_0001, ready=1 -> next cycle valid=1, Y=0, pend_cnt=1; following cycle valid=0, pend_cnt=0.
REQ-026 PRIO_HIGH=1, load A=8'b1010_0100, ready held 1 -> Y=7,5,2 on three consecutive cycles, pend_cnt 3,2,1, then valid=0, pend_cnt=0.
REQ-027 PRIO_HIGH=0, same stimulus -> Y=2,5,7 on consecutive cycles.
REQ-028 ready=0, Y=5 offered, load A=8'b1000_0000 -> Y stays 5, pend_cnt increments by 1; raise ready -> after transfer Y=7.
REQ-029 Bit 3 pending and not offered, load A=8'b0000_1000 -> dup=1 for one cycle, pend_cnt unchanged; transfer of bit 3 with same-edge reload of bit 3 -> dup=0, bit 3 still pending.
REQ-030 rst_n pulsed low while valid=1 and pend_cnt=4 -> valid=0, Y=0, pend_cnt=0 without a clock edge; no code emitted afterwards until a new load.

Source files
------------

// File: rtl/enc8_3_seq.sv
// enc8_3_seq: sequential 8-to-3 priority encoder with a pending-event register.
// Every bit loaded through A is remembered until its code has been handed to
// the consumer; codes are offered one at a time with a valid/ready handshake.
//
// state | meaning
// IDLE  | nothing pending, valid low, Y keeps the last code offered
// OFFER | Y holds a pending bit's index, waiting for ready
module enc8_3_seq #(
  parameter int PRIO_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] A,
  input  logic       ready,
  output logic [2:0] Y,
  output logic       valid,
  output logic [3:0] pend_cnt,
  output logic       dup
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] pending;
  logic       xfer;
  logic [7:0] xfer_mask;
  logic [7:0] kept;
  logic [7:0] pending_next;

  // Index of the bit that wins priority within v (0 when v is empty).
  function automatic logic [2:0] prio_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (PRIO_HIGH != 0) begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // Number of set bits in v.
  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

  // Next pending set: drop the bit handed over this edge, then merge the new load.
  always_comb begin
    xfer      = (state == OFFER) && ready;
    xfer_mask = 8'h00;
    if (xfer) xfer_mask[Y] = 1'b1;
    kept         = pending & ~xfer_mask;
    pending_next = kept | (load ? A : 8'h00);
  end

  // Handshake FSM with all outputs registered; the offered code only moves on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= 8'h00;
      Y        <= 3'd0;
      valid    <= 1'b0;
      pend_cnt <= 4'd0;
      dup      <= 1'b0;
    end else begin
      pending  <= pending_next;
      pend_cnt <= popcount(pending_next);
      // A bit cleared by this edge's transfer is not a duplicate if reloaded.
      dup      <= load && ((A & kept) != 8'h00);
      case (state)
        IDLE: begin
          if (pending_next != 8'h00) begin
            state <= OFFER;
            valid <= 1'b1;
            Y     <= prio_idx(pending_next);
          end
        end
        OFFER: begin
          if (xfer) begin
            if (pending_next != 8'h00) begin
              Y <= prio_idx(pending_next);
            end else begin
              state <= IDLE;
              valid <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc8_3_seq.sv
// Bench for enc8_3_seq: both priority orders run side by side on shared stimulus.
module tb_enc8_3_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [7:0] a;
  logic       ready;
  logic [2:0] y_hi, y_lo;
  logic       valid_hi, valid_lo;
  logic [3:0] cnt_hi, cnt_lo;
  logic       dup_hi, dup_lo;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  enc8_3_seq #(.PRIO_HIGH(1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .load(load), .A(a), .ready(ready),
    .Y(y_hi), .valid(valid_hi), .pend_cnt(cnt_hi), .dup(dup_hi)
  );

  enc8_3_seq #(.PRIO_HIGH(0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .load(load), .A(a), .ready(ready),
    .Y(y_lo), .valid(valid_lo), .pend_cnt(cnt_lo), .dup(dup_lo)
  );

  // Reference: pending set as a plain bit set, offered code as an integer.
  // Index 0 models bit-7-first priority, index 1 bit-0-first.
  logic [7:0] m_pend [2];
  int         m_y    [2];
  bit         m_valid[2];
  bit         m_dup  [2];

  function automatic int pick(input logic [7:0] p, input bit hi);
    if (hi) begin
      for (int i = 7; i >= 0; i--) if (p[i]) return i;
    end else begin
      for (int i = 0; i < 8; i++) if (p[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 8'h00; m_y[k] = 0; m_valid[k] = 0; m_dup[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit hi);
    logic [7:0] p;
    bit handed;
    p      = m_pend[k];
    handed = m_valid[k] && ready;
    if (handed) p[m_y[k]] = 1'b0;
    m_dup[k] = load && ((a & p) != 8'h00);
    if (load) p = p | a;
    if (!m_valid[k] || handed) begin
      if (p != 8'h00) begin
        m_valid[k] = 1;
        m_y[k]     = pick(p, hi);
      end else begin
        m_valid[k] = 0;
      end
    end
    m_pend[k] = p;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    @(negedge clk);
  endtask

  task automatic drive(input bit l, input logic [7:0] v, input bit r);
    load = l; a = v; ready = r;
  endtask

  task automatic check_vs_model(input string tag);
    check({tag, " valid_hi"}, int'(valid_hi), int'(m_valid[0]));
    check({tag, " y_hi"},     int'(y_hi),     m_y[0]);
    check({tag, " cnt_hi"},   int'(cnt_hi),   $countones(m_pend[0]));
    check({tag, " dup_hi"},   int'(dup_hi),   int'(m_dup[0]));
    check({tag, " valid_lo"}, int'(valid_lo), int'(m_valid[1]));
    check({tag, " y_lo"},     int'(y_lo),     m_y[1]);
    check({tag, " cnt_lo"},   int'(cnt_lo),   $countones(m_pend[1]));
    check({tag, " dup_lo"},   int'(dup_lo),   int'(m_dup[1]));
  endtask

  typedef struct {
    bit         load;
    logic [7:0] a;
    bit         ready;
    int         y_hi;
    int         y_lo;
    bit         valid;
    int         cnt;
    bit         dup;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit l, logic [7:0] v, bit r, int yh, int yl, bit vd, int c, bit d);
    vec_t t;
    t.load = l; t.a = v; t.ready = r; t.y_hi = yh; t.y_lo = yl;
    t.valid = vd; t.cnt = c; t.dup = d;
    return t;
  endfunction

  initial begin
    // single bit in and out
    vecs.push_back(mk(1, 8'h01, 1, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0));
    // three bits drained back to back in each priority order
    vecs.push_back(mk(1, 8'hA4, 1, 7, 2, 1, 3, 0));
    vecs.push_back(mk(0, 8'h00, 1, 5, 5, 1, 2, 0));
    vecs.push_back(mk(0, 8'h00, 1, 2, 7, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 2, 7, 0, 0, 0));
    // load of zero is ignored
    vecs.push_back(mk(1, 8'h00, 1, 2, 7, 0, 0, 0));
    // offered code held while stalled, even against a higher-priority arrival
    vecs.push_back(mk(1, 8'h20, 0, 5, 5, 1, 1, 0));
    vecs.push_back(mk(1, 8'h80, 0, 5, 5, 1, 2, 0));
    vecs.push_back(mk(0, 8'h00, 1, 7, 7, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 7, 7, 0, 0, 0));
    // duplicate of a pending, non-offered bit
    vecs.push_back(mk(1, 8'h89, 0, 7, 0, 1, 3, 0));
    vecs.push_back(mk(1, 8'h08, 0, 7, 0, 1, 3, 1));
    vecs.push_back(mk(0, 8'h00, 0, 7, 0, 1, 3, 0));
    // bit 3 handed over and reloaded on the same edge: no dup, still pending
    vecs.push_back(mk(0, 8'h00, 1, 3, 3, 1, 2, 0));
    vecs.push_back(mk(1, 8'h08, 1, 3, 3, 1, 2, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 7, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 7, 0, 0, 0));

    rst_n = 1'b0;
    drive(0, 8'h00, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_vs_model("reset");
    check("reset y_hi const", int'(y_hi), 0);
    check("reset valid_hi const", int'(valid_hi), 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].load, vecs[i].a, vecs[i].ready);
      tick();
      check($sformatf("vec%0d y_hi", i),     int'(y_hi),     vecs[i].y_hi);
      check($sformatf("vec%0d y_lo", i),     int'(y_lo),     vecs[i].y_lo);
      check($sformatf("vec%0d valid_hi", i), int'(valid_hi), int'(vecs[i].valid));
      check($sformatf("vec%0d valid_lo", i), int'(valid_lo), int'(vecs[i].valid));
      check($sformatf("vec%0d cnt_hi", i),   int'(cnt_hi),   vecs[i].cnt);
      check($sformatf("vec%0d cnt_lo", i),   int'(cnt_lo),   vecs[i].cnt);
      check($sformatf("vec%0d dup_hi", i),   int'(dup_hi),   int'(vecs[i].dup));
      check($sformatf("vec%0d dup_lo", i),   int'(dup_lo),   int'(vecs[i].dup));
    end

    // asynchronous reset in the middle of an offer
    drive(1, 8'h0F, 0);
    tick();
    check("pre-reset cnt_hi", int'(cnt_hi), 4);
    check("pre-reset valid_hi", int'(valid_hi), 1);
    drive(0, 8'h00, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async valid_hi", int'(valid_hi), 0);
    check("async y_hi", int'(y_hi), 0);
    check("async cnt_hi", int'(cnt_hi), 0);
    check("async valid_lo", int'(valid_lo), 0);
    check("async y_lo", int'(y_lo), 0);
    check("async cnt_lo", int'(cnt_lo), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post-reset idle%0d valid_hi", i), int'(valid_hi), 0);
      check($sformatf("post-reset idle%0d valid_lo", i), int'(valid_lo), 0);
    end
    drive(1, 8'h40, 1);
    tick();
    check("first load valid_hi", int'(valid_hi), 1);
    check("first load y_hi", int'(y_hi), 6);
    check("first load cnt_lo", int'(cnt_lo), 1);

    // randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      drive(bit'($urandom_range(0, 1)), 8'($urandom & $urandom), $urandom_range(0, 3) != 0);
      tick();
      check_vs_model($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
